// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared funct3 encodings, FSM states and request checks for the
//            load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // Misalignment or an unsupported funct3; the range check lives in the top.
    function automatic logic lsu_req_illegal(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (funct3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = off[0];
                F3_W:    bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = off[0];
                F3_W:        bad = (off != 2'b00);
                default:     bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane extract/extend for loads and lane merge for
//            sub-word stores.
// Revision : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata_i[{byte_off_i, 3'b000} +: 8];
        w_half = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
            F3_BU:   load_data_o = {24'h000000, w_byte};
            F3_HU:   load_data_o = {16'h0000, w_half};
            default: load_data_o = rdata_i;
        endcase

        merge_data_o = rdata_i;
        case (funct3_i)
            F3_B: merge_data_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H: begin
                if (byte_off_i[1]) begin
                    merge_data_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_data_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding RV32I load/store initiator for a word-only
//            data memory with combinational read and clocked write.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_WE,
    output logic [31:0]           mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    localparam logic [29:0] c_DEPTH_LIMIT = 30'(ADDR_DEPTH);

    lsu_state_e            state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  w_req_err;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge_data;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .byte_off_i   (addr_q[1:0]),
        .rdata_i      (mem_RD),
        .wdata_i      (wdata_q),
        .load_data_o  (w_load_data),
        .merge_data_o (w_merge_data)
    );

    assign w_req_err = lsu_req_illegal(req_we, req_funct3, req_addr[1:0])
                     || (req_addr[31:2] >= c_DEPTH_LIMIT);

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = rdata_q;
    assign mem_A     = {addr_q[31:2], 2'b00};
    // SW bypasses the merge buffer; SB/SH write the merged word.
    assign mem_WD    = (funct3_q == F3_W) ? wdata_q : merge_q;
    assign mem_WE    = (state_q == ST_WRITE) && !rst;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = w_req_err;
                    if (w_req_err) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = w_load_data;
                state_d = ST_RESP;
            end
            ST_MERGE: begin
                merge_d = w_merge_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed and randomized checks of load_store_unit against a
//            byte-addressed reference memory.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] ram [0:DEPTH-1];
    logic [7:0]  ref_mem [0:DEPTH*4-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] g_rdata;
    logic        g_err;
    int          g_accept_cyc;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_WE     (mem_WE),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_RD = ram[mem_A[7:2]];
    always @(posedge clk) if (mem_WE) ram[mem_A[7:2]] <= mem_WD;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        ram[idx] <= v;
        for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = v[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (a[31:2] >= 30'(DEPTH)) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << f3[1:0];
        v = 32'h0;
        for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[int'(a[7:0]) + k]) << (8*k));
        if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat, nb, lat, we_cnt, wait_n;
        exp_err = model_err(we, f3, a);
        nb      = 1 << f3[1:0];
        exp_rd  = (!exp_err && !we) ? model_load(f3, a) : 32'h0;
        exp_lat = exp_err ? 1 : ((we && nb < 4) ? 3 : 2);

        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        g_accept_cyc = cyc;

        lat = 0; we_cnt = 0; g_rdata = 32'h0; g_err = 1'b0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (mem_WE) we_cnt++;
            if (rsp_valid) begin
                lat = n; g_rdata = rsp_rdata; g_err = rsp_err;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_err"}, 32'(g_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, g_rdata, exp_rd);
        check_eq({tag, "_we_cycles"}, 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);

        @(negedge clk);
        check_eq({tag, "_pulse_end"}, {30'h0, rsp_valid, req_ready}, 32'd1);

        if (we && !exp_err)
            for (int k = 0; k < nb; k++) ref_mem[int'(a[7:0]) + k] = wd[8*k +: 8];
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [1:0]  m;
        int          r, sw_cyc;

        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp", {29'h0, rsp_valid, rsp_err, mem_WE}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        check_eq("rst_mem_A", mem_A, 32'h0);
        check_eq("rst_mem_WD", mem_WD, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);

        // Sign/zero extension of lanes within one word.
        preload(3, 32'h8081_7F82);
        @(negedge clk);
        do_op(1'b0, F3_B, 32'h0C, 32'h0, "lb");
        check_eq("lb_value", g_rdata, 32'hFFFF_FF82);
        do_op(1'b0, F3_BU, 32'h0D, 32'h0, "lbu");
        check_eq("lbu_value", g_rdata, 32'h0000_007F);
        do_op(1'b0, F3_H, 32'h0E, 32'h0, "lh");
        check_eq("lh_value", g_rdata, 32'hFFFF_8081);

        preload(3, 32'h1122_3344);
        @(negedge clk);
        do_op(1'b1, F3_B, 32'h0D, 32'h0000_00AB, "sb");
        check_eq("sb_mem", ram[3], 32'h1122_AB44);

        do_op(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, "sw");
        sw_cyc = g_accept_cyc;
        do_op(1'b0, F3_W, 32'h10, 32'h0, "lw");
        check_eq("lw_value", g_rdata, 32'hDEAD_BEEF);
        check_eq("sw_lw_spacing", 32'(g_accept_cyc - sw_cyc), 32'd3);

        do_op(1'b0, F3_H, 32'h03, 32'h0, "err_misalign");
        do_op(1'b1, F3_W, 32'h102, 32'h5555_AAAA, "err_range");
        do_op(1'b0, 3'b011, 32'h0, 32'h0, "err_funct3");

        // Reset during WRITE must suppress the store and drop the response.
        preload(8, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H;
        req_addr = 32'h20; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstw_in_write", 32'(mem_WE), 32'd1);
        rst = 1'b1;
        #1 check_eq("rstw_we_gated", 32'(mem_WE), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_after", {30'h0, rsp_valid, req_ready}, 32'd1);
        @(negedge clk);
        check_eq("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("rstw_mem", ram[8], 32'hCAFE_F00D);

        for (int i = 0; i < 1000; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                r  = $urandom_range(0, 4);
                f3 = (r == 3) ? F3_BU : (r == 4) ? F3_HU : 3'(r);
            end
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'($urandom_range(256, 300));
            else             a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                m = (f3[1:0] == 2'd2) ? 2'b00 : (f3[1:0] == 2'd1) ? 2'b10 : 2'b11;
                a[1:0] = a[1:0] & m;
            end
            do_op(we, f3, a, $urandom, "rnd");
        end

        for (int i = 0; i < DEPTH; i++) check_eq("final_mem", ram[i], ref_word(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's word-organised data-memory port. Accepts one load/store request at a time from the execute stage. Drives the memory's write-enable/address/write-data lines and consumes its combinational read data. Implements RV32I byte/halfword semantics (LB/LH/LW/LBU/LHU/SB/SH/SW) on a word-only memory: sign/zero extension for loads, read-modify-write for sub-word stores.

## Interface
- `DATA_WIDTH`, 32 — memory word width; only 32 is supported.
- `ADDR_DEPTH`, 64 — number of words in the attached memory; word index = addr[31:2].
- `clk` in 1 — clock; every register updates on the rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — unit can accept a request.
- `req_we` in 1 — 1 = store, 0 = load.
- `req_funct3` in 3 — RV32I funct3 of the memory instruction.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data; right-aligned, only the low byte/half is used for SB/SH.
- `rsp_valid` out 1 — one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 32 — extended load result; 0 for stores and errors.
- `rsp_err` out 1 — request rejected because it was misaligned, used an illegal funct3, or was out of range; valid with `rsp_valid`.
- `mem_WE` out 1 — memory write enable; the memory writes on the rising edge of `clk`.
- `mem_A` out 32 — memory address; always word-aligned {addr[31:2],2'b00}.
- `mem_WD` out 32 — memory write data.
- `mem_RD` in 32 — memory read data; combinational from `mem_A`.

## Operation
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, we, funct3 and wdata.
  - If the request is an error, go to RESP with err=1.
  - Else a load goes to LOAD, SW goes to WRITE, and SB/SH goes to MERGE.
- **LOAD**
  - `mem_A` = latched word address.
  - Select a byte by addr[1:0] or a half by addr[1], then extend:
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
    - LW passes the word through.
  - Register the result into `rsp_rdata`, then go to RESP.
- **MERGE**
  - Capture `mem_RD` and replace the addressed byte/half lane with wdata[7:0]/wdata[15:0] into a merge buffer.
  - Go to WRITE.
- **WRITE**
  - `mem_WE`=1 and `mem_WD` = merge buffer (SB/SH) or wdata (SW), for exactly one cycle.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1 for one cycle, then go to IDLE.
  - `req_ready`=0, so back-to-back requests are spaced by the FSM.
- **Error conditions:**
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal funct3: load funct3 ∈ {011,110,111}; store funct3 ∉ {000,001,010}.
  - Out of range: addr[31:2] ≥ `ADDR_DEPTH`.
  - An error request causes no memory access: `mem_WE` stays 0.
- `mem_WE` is gated with `!rst`, so a reset asserted in WRITE suppresses the write.
- `mem_A`/`mem_WD` are don't-care while `mem_WE`=0 outside LOAD/MERGE, but are driven from latched registers (no X).

## Timing
- Reset values:
  - state=IDLE.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_WE`=0, `mem_A`=0, `mem_WD`=0.
  - All latches=0.
  - `req_ready`=0 during the reset cycle, 1 in the first cycle after.
- Latency, from the accept edge (cycle 0) to `rsp_valid` high:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- Memory write occurs at the end of the WRITE cycle; the response follows in the next cycle, so read-after-write from the next request sees new data.
- Reset mid-operation: on the next edge the FSM returns to IDLE and any pending response is dropped.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum/localparams.
- Sub-module `lsu_align` (combinational), performing load extract/extend and store lane merge from funct3 + addr[1:0]. It is reused by both the LOAD and MERGE paths.

## Test plan
- Preload word 3 = 0x8081_7F82.
  - LB @0x0C → 0xFFFF_FF82.
  - LBU @0x0D → 0x0000_007F.
  - LH @0x0E → 0xFFFF_8081.
- SB 0xAB @0x0D onto 0x1122_3344 → memory word becomes 0x1122_AB44.
  - `mem_WE` is high exactly 1 cycle.
  - `rsp_valid` at cycle 3.
- SW 0xDEAD_BEEF @0x10, then LW @0x10 → 0xDEAD_BEEF; request spacing is 3 cycles apart.
- LH @0x03, SW @0x102 (ADDR_DEPTH=64), load funct3=011 → each gives `rsp_err`=1 at cycle 1, `mem_WE` never asserts, `rsp_rdata`=0.
- Assert `rst` during the WRITE cycle of SH 0x1234 @0x20 → memory unchanged, no `rsp_valid`, `req_ready`=1 one cycle after `rst` deasserts.
- Random load/store stream (1000 ops) compared against a byte-array reference model.
